// File: rtl/aes_pkg.sv
// Shared AES sequencer definitions: controller states,
// block width and round-count constants.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;
    localparam int RK_IDX_W      = 4;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: initial AddRoundKey, then one pass
// through the shared round datapath per round, result on valid/ready.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS    = 10,
    parameter int ROUND_LATENCY = 2,
    parameter int DATA_W        = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [DATA_W-1:0]   rk_data,
    output logic [DATA_W-1:0]   ru_data,
    output logic [DATA_W-1:0]   ru_key,
    output logic                ru_final,
    input  logic [DATA_W-1:0]   ru_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy,
    output logic [3:0]          cur_round
);

    if (!(NUM_ROUNDS == AES128_ROUNDS || NUM_ROUNDS == AES192_ROUNDS ||
          NUM_ROUNDS == AES256_ROUNDS)) begin : g_bad_rounds
        $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
    end
    if (ROUND_LATENCY < 1) begin : g_bad_latency
        $error("aes_round_ctrl: ROUND_LATENCY must be at least 1");
    end
    if (DATA_W != AES_BLOCK_W) begin : g_bad_width
        $error("aes_round_ctrl: DATA_W must be 128");
    end

    localparam int PH_W = (ROUND_LATENCY < 1) ? 1 : $clog2(ROUND_LATENCY + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(ROUND_LATENCY);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t            state, state_n;
    logic [DATA_W-1:0] state_reg, state_reg_n;
    logic [3:0]        round, round_n;
    logic [PH_W-1:0]   ph, ph_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            round     <= '0;
            ph        <= '0;
        end else begin
            state     <= state_n;
            state_reg <= state_reg_n;
            round     <= round_n;
            ph        <= ph_n;
        end
    end

    always_comb begin
        state_n     = state;
        state_reg_n = state_reg;
        round_n     = round;
        ph_n        = ph;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_reg_n = in_data ^ rk_data;
                    round_n     = 4'd1;
                    ph_n        = '0;
                    state_n     = RUN;
                end
            end
            RUN: begin
                // Round inputs have been stable ROUND_LATENCY edges here.
                if (ph == PH_LAST) begin
                    state_reg_n = ru_result;
                    ph_n        = '0;
                    if (round == LAST_ROUND) begin
                        state_n = DONE;
                    end else begin
                        round_n = round + 4'd1;
                    end
                end else begin
                    ph_n = ph + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rk_idx    = (state == RUN) ? round : '0;
    assign ru_final  = (state == RUN) && (round == LAST_ROUND);
    assign ru_data   = state_reg;
    assign ru_key    = rk_data;
    assign out_data  = state_reg;
    assign cur_round = round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a behavioural AES round unit,
// key store and reference cipher; also covers a ROUND_LATENCY=1 build.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR  = 10;
    localparam int RL  = 2;
    localparam int RL1 = 1;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, ru_final, out_valid, out_ready, busy;
    logic [127:0] in_data, rk_data, ru_data, ru_key, ru_result, out_data;
    logic [3:0]   rk_idx, cur_round;

    logic         in_valid1, in_ready1, ru_final1, out_valid1, out_ready1, busy1;
    logic [127:0] in_data1, rk_data1, ru_data1, ru_key1, ru_result1, out_data1;
    logic [3:0]   rk_idx1, cur_round1;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_LATENCY(RL), .DATA_W(128)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk_data(rk_data),
        .ru_data(ru_data), .ru_key(ru_key), .ru_final(ru_final),
        .ru_result(ru_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .cur_round(cur_round)
    );

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_LATENCY(RL1), .DATA_W(128)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .rk_idx(rk_idx1), .rk_data(rk_data1),
        .ru_data(ru_data1), .ru_key(ru_key1), .ru_final(ru_final1),
        .ru_result(ru_result1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1), .cur_round(cur_round1)
    );

    // ---------------- AES reference (FIPS-197 byte/column order) ----------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic gen_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = sbox[b[r+4*((c+r)%4)]];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [11*128-1:0] expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [11*128-1:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[11*128-1-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [11*128-1:0] ex;
        logic [127:0] s;
        ex = expand(key);
        s = pt ^ ex[11*128-1 -: 128];
        for (int r = 1; r <= 10; r++)
            s = aes_round(s, ex[11*128-1-128*r -: 128], r == 10);
        return s;
    endfunction

    // ---------------- key stores and round datapaths ----------------------
    logic [127:0] rk0 [16];
    logic [127:0] rk1 [16];
    logic [127:0] cur_key;
    assign rk_data  = rk0[rk_idx];
    assign rk_data1 = rk1[rk_idx1];

    task automatic load_keys(input logic [127:0] key, output logic [127:0] ks [16]);
        logic [11*128-1:0] ex;
        ex = expand(key);
        for (int i = 0; i < 16; i++)
            ks[i] = (i < 11) ? ex[11*128-1-128*i -: 128] : 128'h0;
    endtask

    logic [127:0] pipe0 [RL];
    logic [127:0] pipe1;
    always @(posedge clk) begin
        pipe0[0] <= aes_round(ru_data, ru_key, ru_final);
        for (int i = 1; i < RL; i++) pipe0[i] <= pipe0[i-1];
        pipe1 <= aes_round(ru_data1, ru_key1, ru_final1);
    end
    assign ru_result  = pipe0[RL-1];
    assign ru_result1 = pipe1;

    // ---------------- bookkeeping ----------------------------------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] exp_q [$];
    bit trk = 1'b0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    bit go1 = 1'b0;
    bit d1_done = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timeout", nm);
    endtask

    // Monitor: pops expected ciphertext on each output handshake and checks
    // the per-round key index schedule against elapsed cycles.
    initial begin
        int k, er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (trk) begin
                    k = cyc - acc_cyc + 1;
                    if (k >= 1 && k <= NR * (RL + 1)) begin
                        er = (k - 1) / (RL + 1) + 1;
                        chk("rk_idx_sched", rk_idx, er);
                        chk("ru_final_sched", ru_final, er == NR);
                        chk("run_flags", {busy, in_ready, out_valid}, 3'b100);
                    end else if (k == NR * (RL + 1) + 1) begin
                        chk("latency_out_valid", out_valid, 1'b1);
                        trk = 1'b0;
                    end
                end
                if (out_valid && out_ready) begin
                    hs_cyc = cyc + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %h expected none", out_data);
                    end else begin
                        chk("ciphertext", out_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] pt);
        int n;
        in_valid = 1'b1;
        in_data  = pt;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                fail_now("accept_wait");
                in_valid = 1'b0;
                return;
            end
        end
        chk("rk_idx_accept", rk_idx, 4'd0);
        exp_q.push_back(aes_enc(pt, cur_key));
        acc_cyc = cyc + 1;
        trk = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
            n++;
            if (n > 300) begin
                fail_now("idle_wait");
                return;
            end
        end
    endtask

    // ROUND_LATENCY=1 build runs the FIPS vector alongside the main tests.
    initial begin
        int n, a1;
        in_valid1 = 1'b0;
        in_data1 = '0;
        out_ready1 = 1'b1;
        wait (go1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        in_data1 = FIPS_PT;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready1 && n < 50);
        a1 = cyc + 1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid1 && n < 100);
        if (!out_valid1) fail_now("rl1_out_valid");
        chk("rl1_latency", cyc - a1 + 1, 21);
        chk("rl1_ciphertext", out_data1, FIPS_CT);
        d1_done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, hold;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        gen_sbox();
        load_keys(FIPS_KEY, rk0);
        load_keys(FIPS_KEY, rk1);
        cur_key = FIPS_KEY;
        chk("model_fips", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rk_idx", rk_idx, 4'd0);
        chk("rst_ru_final", ru_final, 1'b0);
        chk("rst_ru_data", ru_data, 128'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        go1 = 1'b1;

        // FIPS-197 vector, latency and schedule checked by the monitor
        @(posedge clk);
        #1;
        send(FIPS_PT);
        wait_idle();

        // Random keys and blocks with random idle gaps
        for (int t = 0; t < 4; t++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            cur_key = {$urandom, $urandom, $urandom, $urandom};
            load_keys(cur_key, rk0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(pt);
            wait_idle();
        end

        // Backpressure in DONE with a competing in_valid
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) fail_now("bp_out_valid");
        hold = out_data;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_out_valid_hold", out_valid, 1'b1);
            chk("bp_out_data_hold", out_data, hold);
            chk("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom});
        chk("bp_accept_gap", acc_cyc - hs_cyc, 1);
        wait_idle();

        // Asynchronous reset during round 5 abandons the block
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_round != 4'd5 && n < 100);
        if (cur_round != 4'd5) fail_now("reset_round5_wait");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        exp_q.delete();
        trk = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        cur_key = FIPS_KEY;
        load_keys(FIPS_KEY, rk0);
        @(posedge clk);
        #1;
        send(FIPS_PT);
        wait_idle();

        // Back-to-back: in_valid stays high across both transactions
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom});
        chk("b2b_accept_gap", acc_cyc - hs_cyc, 1);
        wait_idle();

        n = 0;
        while (!d1_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!d1_done) fail_now("rl1_done");
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
